// File: rtl/ir_pkg.sv
// Shared widths, instruction bundle and beat arithmetic for the instruction register.
package ir_pkg;

    localparam int DEF_BUS_W  = 8;
    localparam int DEF_OP_W   = 3;
    localparam int DEF_ADDR_W = 13;

    typedef struct packed {
        logic [DEF_OP_W-1:0]   opcode;
        logic [DEF_ADDR_W-1:0] addr;
    } instr_t;

    function automatic int beat_count(input int op_w, input int addr_w, input int bus_w);
        return (op_w + addr_w) / bus_w;
    endfunction

endpackage

// File: rtl/ir_beat_counter.sv
// Beat sequencing: accept/abort/last-beat decode for one instruction frame.
// With IR_PARITY_EN the frame carries one trailing parity beat.
module ir_beat_counter
    import ir_pkg::*;
#(
    parameter int BEATS = 2
) (
    input  logic CLK_CTRL,
    input  logic RESET,
    input  logic enable,
    input  logic in_ready,
    output logic accept,
    output logic data_beat,
    output logic last
);

`ifdef IR_PARITY_EN
    localparam int TOTAL = BEATS + 1;
`else
    localparam int TOTAL = BEATS;
`endif
    localparam int CW = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    logic [CW-1:0] cnt;
    logic          abort;

    assign accept = enable && in_ready;
    assign abort  = !enable && (cnt != '0);
    assign last   = accept && (cnt == CW'(TOTAL - 1));
`ifdef IR_PARITY_EN
    assign data_beat = accept && (cnt != CW'(BEATS));
`else
    assign data_beat = accept;
`endif

    // A stalled beat (enable high, in_ready low) holds the count.
    always_ff @(posedge CLK_CTRL) begin
        if (RESET || abort) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ir_stream_assembler.sv
// Instruction register: assembles MSB-first bus beats into {OPCODE, ADDR_IR} with one staging slot.
// Optional IR_PARITY_EN adds a trailing even-parity beat and a sticky PARITY_ERR flag.
module ir_stream_assembler
    import ir_pkg::*;
#(
    parameter int BUS_W  = DEF_BUS_W,
    parameter int OP_W   = DEF_OP_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              CLK_CTRL,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic [BUS_W-1:0]  DATA_BUS,
    output logic              IN_READY,
    output logic [OP_W-1:0]   OPCODE,
    output logic [ADDR_W-1:0] ADDR_IR,
    output logic              INSTR_VALID,
    input  logic              INSTR_ACK,
    output logic              PARITY_ERR
);

    localparam int IW    = OP_W + ADDR_W;
    localparam int BEATS = beat_count(OP_W, ADDR_W, BUS_W);

    logic          accept;
    logic          data_beat;
    logic          complete;
    logic [IW-1:0] asm_q;
    logic [IW-1:0] shifted;
    logic [IW-1:0] new_word;
    logic [IW-1:0] out_q;
    logic [IW-1:0] stage_q;
    logic          stage_full;
    logic          valid_q;
    logic          ack_eff;
    logic          out_free;

    ir_beat_counter #(.BEATS(BEATS)) u_cnt (
        .CLK_CTRL  (CLK_CTRL),
        .RESET     (RESET),
        .enable    (ENABLE),
        .in_ready  (IN_READY),
        .accept    (accept),
        .data_beat (data_beat),
        .last      (complete)
    );

    generate
        if (IW > BUS_W) begin : g_shift
            assign shifted = {asm_q[IW-BUS_W-1:0], DATA_BUS};
        end else begin : g_single
            assign shifted = DATA_BUS;
        end
    endgenerate

    always_ff @(posedge CLK_CTRL) begin
        if (RESET) begin
            asm_q <= '0;
        end else if (data_beat) begin
            asm_q <= shifted;
        end
    end

`ifdef IR_PARITY_EN
    assign new_word = asm_q;

    always_ff @(posedge CLK_CTRL) begin
        if (RESET) begin
            PARITY_ERR <= 1'b0;
        end else if (complete && ((^asm_q) != DATA_BUS[0])) begin
            PARITY_ERR <= 1'b1;
        end
    end
`else
    assign new_word   = shifted;
    assign PARITY_ERR = 1'b0;
`endif

    assign ack_eff  = INSTR_ACK && valid_q;
    assign out_free = !valid_q || (ack_eff && !stage_full);
    assign IN_READY = !(stage_full && valid_q && !INSTR_ACK);

    // Output changes only as a whole word: on completion or promotion.
    always_ff @(posedge CLK_CTRL) begin
        if (RESET) begin
            out_q      <= '0;
            stage_q    <= '0;
            stage_full <= 1'b0;
            valid_q    <= 1'b0;
        end else if (ack_eff && stage_full) begin
            out_q <= stage_q;
            if (complete) begin
                stage_q <= new_word;
            end else begin
                stage_full <= 1'b0;
            end
        end else if (complete) begin
            if (out_free) begin
                out_q   <= new_word;
                valid_q <= 1'b1;
            end else begin
                stage_q    <= new_word;
                stage_full <= 1'b1;
            end
        end else if (ack_eff) begin
            valid_q <= 1'b0;
        end
    end

    assign OPCODE      = out_q[IW-1 -: OP_W];
    assign ADDR_IR     = out_q[ADDR_W-1:0];
    assign INSTR_VALID = valid_q;

endmodule

// File: tb/tb_ir_stream_assembler.sv
// Directed bench for ir_stream_assembler: framing, abort, stall/staging, ack overlap, reset, parity.
module tb_ir_stream_assembler;

    localparam int BUS_W  = 8;
    localparam int OP_W   = 3;
    localparam int ADDR_W = 13;
    localparam int BEATS  = 2;
`ifdef IR_PARITY_EN
    localparam int NB = BEATS + 1;
`else
    localparam int NB = BEATS;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en  = 1'b0;
    logic              ack = 1'b0;
    logic [BUS_W-1:0]  data = '0;
    logic              in_ready;
    logic [OP_W-1:0]   opcode;
    logic [ADDR_W-1:0] addr;
    logic              valid;
    logic              perr;

    int tests = 0;
    int fails = 0;

    ir_stream_assembler dut (
        .CLK_CTRL    (clk),
        .RESET       (rst),
        .ENABLE      (en),
        .DATA_BUS    (data),
        .IN_READY    (in_ready),
        .OPCODE      (opcode),
        .ADDR_IR     (addr),
        .INSTR_VALID (valid),
        .INSTR_ACK   (ack),
        .PARITY_ERR  (perr)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] beat_of(input logic [15:0] w, input int idx, input bit bad);
        if (idx < BEATS) return 8'(w >> ((BEATS - 1 - idx) * BUS_W));
        return {7'b0, (^w) ^ bad};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [15:0] w, input bit bad);
        for (int i = 0; i < NB; i++) begin
            en   = 1'b1;
            data = beat_of(w, i, bad);
            tick();
        end
        en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests++;
        if ({opcode, addr} !== 16'h0000) begin
            $display("FAIL reset_word got=%h exp=0000", {opcode, addr}); fails++;
        end
        tests++;
        if (valid !== 1'b0) begin
            $display("FAIL reset_valid got=%b exp=0", valid); fails++;
        end
        tests++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready got=%b exp=1", in_ready); fails++;
        end
        tests++;
        if (perr !== 1'b0) begin
            $display("FAIL reset_perr got=%b exp=0", perr); fails++;
        end
    endtask

    task automatic test_basic();
        ack = 1'b1;
        for (int i = 0; i < NB - 1; i++) begin
            en   = 1'b1;
            data = beat_of(16'hA53C, i, 1'b0);
            tick();
        end
        tests++;
        if (valid !== 1'b0) begin
            $display("FAIL basic_early_valid got=%b exp=0", valid); fails++;
        end
        data = beat_of(16'hA53C, NB - 1, 1'b0);
        tick();
        en = 1'b0;
        tests++;
        if (valid !== 1'b1 || opcode !== 3'b101 || addr !== 13'h053C) begin
            $display("FAIL basic_deliver got=%b/%b/%h exp=1/101/053c", valid, opcode, addr); fails++;
        end
        tick();
        tests++;
        if (valid !== 1'b0 || opcode !== 3'b101 || addr !== 13'h053C) begin
            $display("FAIL basic_after_ack got=%b/%b/%h exp=0/101/053c", valid, opcode, addr); fails++;
        end
        ack = 1'b0;
    endtask

    task automatic test_abort();
        ack  = 1'b1;
        en   = 1'b1;
        data = 8'hA5;
        tick();
        en = 1'b0;
        tick();
        tests++;
        if (valid !== 1'b0) begin
            $display("FAIL abort_no_valid got=%b exp=0", valid); fails++;
        end
        feed(16'h2001, 1'b0);
        tests++;
        if (valid !== 1'b1 || opcode !== 3'b001 || addr !== 13'h0001) begin
            $display("FAIL abort_deliver got=%b/%b/%h exp=1/001/0001", valid, opcode, addr); fails++;
        end
        tick();
        tests++;
        if (valid !== 1'b0) begin
            $display("FAIL abort_single got=%b exp=0", valid); fails++;
        end
        ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        ack = 1'b0;
        feed(16'h2345, 1'b0);
        tests++;
        if (valid !== 1'b1 || {opcode, addr} !== 16'h2345 || in_ready !== 1'b1) begin
            $display("FAIL b2b_first got=%b/%h/%b exp=1/2345/1", valid, {opcode, addr}, in_ready); fails++;
        end
        feed(16'h4567, 1'b0);
        tests++;
        if (in_ready !== 1'b0 || {opcode, addr} !== 16'h2345) begin
            $display("FAIL b2b_full got=%b/%h exp=0/2345", in_ready, {opcode, addr}); fails++;
        end
        en   = 1'b1;
        data = beat_of(16'h89AB, 0, 1'b0);
        tick();
        tick();
        tick();
        tests++;
        if (in_ready !== 1'b0 || {opcode, addr} !== 16'h2345 || valid !== 1'b1) begin
            $display("FAIL b2b_stall got=%b/%h/%b exp=0/2345/1", in_ready, {opcode, addr}, valid); fails++;
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tests++;
        if (valid !== 1'b1 || {opcode, addr} !== 16'h4567) begin
            $display("FAIL b2b_second got=%b/%h exp=1/4567", valid, {opcode, addr}); fails++;
        end
        for (int i = 1; i < NB; i++) begin
            data = beat_of(16'h89AB, i, 1'b0);
            tick();
        end
        en = 1'b0;
        tests++;
        if (in_ready !== 1'b0 || {opcode, addr} !== 16'h4567) begin
            $display("FAIL b2b_third_staged got=%b/%h exp=0/4567", in_ready, {opcode, addr}); fails++;
        end
        ack = 1'b1;
        tick();
        tests++;
        if (valid !== 1'b1 || {opcode, addr} !== 16'h89AB) begin
            $display("FAIL b2b_third got=%b/%h exp=1/89ab", valid, {opcode, addr}); fails++;
        end
        tick();
        tests++;
        if (valid !== 1'b0 || {opcode, addr} !== 16'h89AB || in_ready !== 1'b1) begin
            $display("FAIL b2b_drained got=%b/%h/%b exp=0/89ab/1", valid, {opcode, addr}, in_ready); fails++;
        end
        ack = 1'b0;
    endtask

    task automatic test_ack_overlap();
        ack = 1'b0;
        feed(16'h1357, 1'b0);
        for (int i = 0; i < NB - 1; i++) begin
            en   = 1'b1;
            data = beat_of(16'hF00D, i, 1'b0);
            tick();
        end
        ack  = 1'b1;
        data = beat_of(16'hF00D, NB - 1, 1'b0);
        tick();
        ack = 1'b0;
        en  = 1'b0;
        tests++;
        if (valid !== 1'b1 || {opcode, addr} !== 16'hF00D) begin
            $display("FAIL overlap_new got=%b/%h exp=1/f00d", valid, {opcode, addr}); fails++;
        end
        tick();
        tests++;
        if (valid !== 1'b1 || {opcode, addr} !== 16'hF00D) begin
            $display("FAIL overlap_hold got=%b/%h exp=1/f00d", valid, {opcode, addr}); fails++;
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tests++;
        if (valid !== 1'b0) begin
            $display("FAIL overlap_no_dup got=%b exp=0", valid); fails++;
        end
    endtask

    task automatic test_mid_reset();
        ack = 1'b0;
        feed(16'h2222, 1'b0);
        feed(16'h4444, 1'b0);
        en   = 1'b1;
        data = beat_of(16'h6666, 0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        en  = 1'b0;
        tests++;
        if ({opcode, addr} !== 16'h0000 || valid !== 1'b0) begin
            $display("FAIL mreset_out got=%h/%b exp=0000/0", {opcode, addr}, valid); fails++;
        end
        tests++;
        if (in_ready !== 1'b1 || perr !== 1'b0) begin
            $display("FAIL mreset_ready got=%b/%b exp=1/0", in_ready, perr); fails++;
        end
        ack = 1'b1;
        feed(16'h2001, 1'b0);
        tests++;
        if (valid !== 1'b1 || {opcode, addr} !== 16'h2001) begin
            $display("FAIL mreset_fresh got=%b/%h exp=1/2001", valid, {opcode, addr}); fails++;
        end
        tick();
        tests++;
        if (valid !== 1'b0) begin
            $display("FAIL mreset_no_stale got=%b exp=0", valid); fails++;
        end
        ack = 1'b0;
    endtask

`ifdef IR_PARITY_EN
    task automatic test_parity();
        ack = 1'b1;
        feed(16'hA53C, 1'b0);
        tests++;
        if (perr !== 1'b0 || valid !== 1'b1) begin
            $display("FAIL parity_good got=%b/%b exp=0/1", perr, valid); fails++;
        end
        feed(16'hA53C, 1'b1);
        tests++;
        if (perr !== 1'b1 || valid !== 1'b1 || {opcode, addr} !== 16'hA53C) begin
            $display("FAIL parity_bad got=%b/%b/%h exp=1/1/a53c", perr, valid, {opcode, addr}); fails++;
        end
        feed(16'h2001, 1'b0);
        tests++;
        if (perr !== 1'b1) begin
            $display("FAIL parity_sticky got=%b exp=1", perr); fails++;
        end
        ack = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (perr !== 1'b0) begin
            $display("FAIL parity_clear got=%b exp=0", perr); fails++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_abort();
        test_back_to_back();
        test_ack_overlap();
        test_mid_reset();
`ifdef IR_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
